i2c_slave_core: RTL and testbench
=================================

// Module: i2c_slave_core
// PURPOSE
//  I2C target (slave) engine, the far end of i2c_master_top on the same bus.
//  - Oversamples SCL/SDA on the core clock and detects START, repeated START and STOP.
//  - Matches a 7-bit address, then receives write bytes into the RX path or serves
//    read bytes from the TX path.
//  - Drives SDA open-drain style for ACK and read data.
// PARAMETERS
//  SLAVE_ADDR   7'h55  own 7-bit bus address
//  SYNC_STAGES  2      synchroniser depth on scl_i/sda_i (>=2)
// PORTS
//  i2c_core_clock_i  in   1  core clock; all logic on rising edge
//  reset_bit_i       in   1  asynchronous, active-low reset
//  enable_bit_i      in   1  1 = block active; 0 = forced idle, SDA released
//  scl_i             in   1  bus SCL (raw pad value)
//  sda_i             in   1  bus SDA (raw pad value)
//  sda_o             out  1  0 = pull SDA low, 1 = release
//  rx_fifo_full_i    in   1  receive FIFO full; forces NACK of write data
//  rx_data_o         out  8  last received data byte
//  rx_valid_o        out  1  1-cycle pulse, rx_data_o valid, byte ACKed
//  tx_data_i         in   8  next byte to return on a read
//  tx_valid_i        in   1  tx_data_i holds a byte
//  tx_ready_o        out  1  1-cycle pulse, tx_data_i consumed
//  addr_rw_o         out  8  {addr[6:0], rw} of the last matched address byte
//  busy_o            out  1  1 from address match until STOP/NACK-end/idle
// BEHAVIOUR
//  Reset: sda_o=1, rx_data_o=0, rx_valid_o=0, tx_ready_o=0, addr_rw_o=0, busy_o=0, state IDLE.
//  Sampling and edges
//   - scl/sda pass through SYNC_STAGES flops; edges are detected on the synchronised copies.
//   - Bus requirement: SCL high and SCL low each >= SYNC_STAGES+3 core clocks.
//   - START: sda falling while scl high. STOP: sda rising while scl high.
//   - Input data is sampled on the scl rising edge.
//   - sda_o changes only in the cycle after a detected scl falling edge.
//  States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
//   IDLE      -> ADDR on START; bit counter cleared.
//   ADDR      - shifts 8 bits MSB first.
//             - Match on {addr}==SLAVE_ADDR: -> ADDR_ACK, addr_rw_o loaded, busy_o=1.
//             - Mismatch -> WAIT_STOP, SDA never driven.
//   ADDR_ACK  - sda_o=0 from the 8th scl fall to the 9th scl fall.
//             - Then rw=0 -> RX_BYTE.
//             - rw=1 -> TX_BYTE: tx_data_i loaded, tx_ready_o pulses if tx_valid_i.
//               If tx_valid_i=0, 8'hFF is sent and there is no tx_ready_o.
//   RX_BYTE   - At the 8th scl rise the byte is complete.
//             - !rx_fifo_full_i: rx_data_o updates and rx_valid_o pulses 1 cycle after that rise.
//             - rx_fifo_full_i (sampled at that rise): byte dropped, no pulse, NACK.
//             -> RX_ACK.
//   RX_ACK    - sda_o=0 (ACK) or 1 (NACK) for the 9th clock.
//             - ACK -> RX_BYTE; NACK -> WAIT_STOP.
//   TX_BYTE   - MSB driven on sda_o at each scl fall; 8 bits.
//             - sda_o released at the 8th fall -> TX_ACK.
//   TX_ACK    - Master bit sampled at the 9th rise.
//             - 0 (ACK): next byte loaded as in ADDR_ACK, -> TX_BYTE.
//             - 1 (NACK): -> WAIT_STOP.
//   WAIT_STOP - sda_o=1; waits for START (-> ADDR) or STOP (-> IDLE).
//  Boundary rules
//   - STOP in any state: -> IDLE, sda_o=1, busy_o=0 in the next cycle; a partial byte is discarded.
//   - Repeated START in any state: -> ADDR, counter cleared, busy_o=0 until the next match.
//   - START and STOP are never simultaneous; if both flags are seen in one cycle, STOP wins.
//   - enable_bit_i=0 mid-transfer: -> IDLE next cycle, sda_o=1, no pulses.
//     Bus activity is then ignored until enable and a fresh START.
//   - Reset asserted mid-transfer: all outputs return to reset values immediately (async).
//   - tx_ready_o and rx_valid_o are never asserted in the same cycle.
//  Widths: bit counter 4 bits (0..8); shift register 8 bits; no arithmetic beyond counting.
// STRUCTURE
//  - i2c_pkg: state encodings, I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_IDLE_BYTE=8'hFF.
//    Shared with the master.
//  - Sub-module i2c_line_filter: synchroniser plus edge detect.
//    Outputs scl_rise, scl_fall, start_det, stop_det and synced sda; reused by the master.
//  - Top: FSM, shift register, bit counter.
// TESTING
//  1 Write: addr 0x55 W, bytes 0xA5, 0x3C, STOP.
//    -> ACK on all 9th clocks; rx_valid_o pulses twice (0xA5 then 0x3C);
//       addr_rw_o=8'hAA; busy_o falls after STOP.
//  2 Mismatch: addr 0x22 W, one byte.
//    -> sda_o stays 1 throughout; no rx_valid_o; busy_o stays 0.
//  3 Read: addr 0x55 R, tx_data_i=0x96 and 0x0F with tx_valid_i=1; master ACK then NACK.
//    -> SDA carries 10010110 then 00001111; tx_ready_o pulses twice; WAIT_STOP then IDLE.
//  4 Full FIFO: write 0x55 W, rx_fifo_full_i=1 on the first data byte.
//    -> NACK on the 9th clock; no rx_valid_o; ignores bits until STOP.
//  5 Repeated START: write 0x55 W + byte 0x11, then Sr + 0x55 R with tx_valid_i=0.
//    -> rx 0x11; read returns 0xFF; addr_rw_o=8'hAB.
//  6 Abort: STOP after the 4th data bit, and separately enable_bit_i=0 mid-byte.
//    -> IDLE within 1 cycle of detection; sda_o=1; no rx_valid_o.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants.
// Used by both the target core and the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic       I2C_ACK       = 1'b0;
  localparam logic       I2C_NACK      = 1'b1;
  localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
// The outputs are decoded from registered copies of the synchronised lines.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus level is high, so reset the chain to 1 to avoid false edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign sda_o       = sda_s;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target engine: address match, write-byte receive and read-byte transmit.
// SDA is driven open-drain style; all state changes follow filtered bus events.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       enable_bit_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic       rx_fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] addr_rw_o,
  output logic       busy_o
);

  i2c_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q;
  logic       ack_q;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [7:0] byte_d;
  logic [7:0] tx_byte_d;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_filter (
    .clk_i      (i2c_core_clock_i),
    .rst_ni     (reset_bit_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_o      (sda_s)
  );

  assign byte_d    = {shift_q[6:0], sda_s};
  assign tx_byte_d = tx_valid_i ? tx_data_i : I2C_IDLE_BYTE;

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ack_q      <= I2C_ACK;
      sda_o      <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      addr_rw_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      // Disable and STOP take priority over START and all bus-phase activity.
      if (!enable_bit_i || stop_det) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        sda_o   <= 1'b1;
        busy_o  <= 1'b0;
      end else if (start_det) begin
        state_q <= ST_ADDR;
        cnt_q   <= '0;
        shift_q <= '0;
        sda_o   <= 1'b1;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: if (scl_rise) begin
            shift_q <= byte_d;
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_q <= '0;
              if (byte_d[7:1] == SLAVE_ADDR) begin
                state_q   <= ST_ADDR_ACK;
                addr_rw_o <= byte_d;
                busy_o    <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_o <= I2C_ACK;
              cnt_q <= 4'd1;
            end else if (addr_rw_o[0]) begin
              state_q    <= ST_TX_BYTE;
              sda_o      <= tx_byte_d[7];
              shift_q    <= {tx_byte_d[6:0], 1'b1};
              tx_ready_o <= tx_valid_i;
              cnt_q      <= 4'd1;
            end else begin
              state_q <= ST_RX_BYTE;
              sda_o   <= 1'b1;
              cnt_q   <= '0;
            end
          end
          ST_RX_BYTE: if (scl_rise) begin
            shift_q <= byte_d;
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_q <= ST_RX_ACK;
              cnt_q   <= '0;
              if (!rx_fifo_full_i) begin
                rx_data_o  <= byte_d;
                rx_valid_o <= 1'b1;
                ack_q      <= I2C_ACK;
              end else begin
                ack_q <= I2C_NACK;
              end
            end
          end
          ST_RX_ACK: if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_o <= ack_q;
              cnt_q <= 4'd1;
            end else begin
              sda_o   <= 1'b1;
              cnt_q   <= '0;
              state_q <= (ack_q == I2C_ACK) ? ST_RX_BYTE : ST_WAIT_STOP;
              busy_o  <= (ack_q == I2C_ACK);
            end
          end
          ST_TX_BYTE: if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_o   <= 1'b1;
              state_q <= ST_TX_ACK;
              cnt_q   <= '0;
            end else begin
              sda_o   <= shift_q[7];
              shift_q <= {shift_q[6:0], 1'b1};
              cnt_q   <= cnt_q + 4'd1;
            end
          end
          // cnt_q=1 records a master ACK; the next byte goes out on the following fall.
          ST_TX_ACK: begin
            if (scl_rise && cnt_q == 4'd0) begin
              if (sda_s == I2C_ACK) begin
                cnt_q <= 4'd1;
              end else begin
                state_q <= ST_WAIT_STOP;
                busy_o  <= 1'b0;
              end
            end else if (scl_fall && cnt_q == 4'd1) begin
              state_q    <= ST_TX_BYTE;
              sda_o      <= tx_byte_d[7];
              shift_q    <= {tx_byte_d[6:0], 1'b1};
              tx_ready_o <= tx_valid_i;
            end
          end
          ST_WAIT_STOP: sda_o <= 1'b1;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-level I2C master model on a wired-AND bus,
// table of transactions plus hand-written abort/restart/reset sequences.
module tb_i2c_slave_core;

  localparam int unsigned Q = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       full = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sda_out, rx_valid, tx_ready, busy;
  logic [7:0] rx_data, addr_rw;
  logic       sda_bus;

  int total = 0;
  int bad = 0;
  int tx_ready_cnt = 0;
  int sda_low_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int unsigned n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        full;
    logic        exp_aack;
    logic [7:0]  exp_arw;
    logic        exp_busy;
  } vec_t;
  vec_t vecs[4];

  assign sda_bus = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_slave_core #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
    .i2c_core_clock_i(clk),
    .reset_bit_i     (rst_n),
    .enable_bit_i    (en),
    .scl_i           (scl),
    .sda_i           (sda_bus),
    .sda_o           (sda_out),
    .rx_fifo_full_i  (full),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .addr_rw_o       (addr_rw),
    .busy_o          (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: rx bytes popped on rx_valid, tx source queue popped on tx_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sda_out) sda_low_cnt++;
      if (rx_valid && tx_ready) begin
        total++;
        bad++;
        $display("FAIL excl: rx_valid and tx_ready both high at %0t", $time);
      end
      if (rx_valid) begin
        if (rxq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexp: got=%0h want=none at %0t", rx_data, $time);
        end else begin
          chk("rx_data", rx_data, rxq.pop_front());
        end
      end
      if (tx_ready) begin
        tx_ready_cnt++;
        if (txq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexp: tx_ready with empty source at %0t", $time);
        end else begin
          void'(txq.pop_front());
        end
      end
    end
    tx_valid = (txq.size() != 0);
    tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = sda_bus;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(2 * Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(2 * Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(mack, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] d[2];
    vec_t       t;

    vecs[0] = '{7'h55, 1'b0, 2, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hAA, 1'b1};
    vecs[1] = '{7'h22, 1'b0, 1, 8'h77, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0};
    vecs[2] = '{7'h55, 1'b1, 2, 8'h96, 8'h0F, 1'b0, 1'b0, 8'hAB, 1'b1};
    vecs[3] = '{7'h55, 1'b0, 2, 8'h5A, 8'hC3, 1'b1, 1'b0, 8'hAA, 1'b1};

    wait_clk(3);
    chk("rst_sda", sda_out, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_addr_rw", addr_rw, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int v = 0; v < 4; v++) begin
      t = vecs[v];
      d[0] = t.d0;
      d[1] = t.d1;
      sda_low_cnt = 0;
      full = t.full;
      if (t.rw) for (int i = 0; i < int'(t.n); i++) txq.push_back(d[i]);
      bus_start();
      wr_byte({t.addr, t.rw}, a);
      chk("addr_ack", a, t.exp_aack);
      chk("busy_mid", busy, t.exp_busy);
      chk("addr_rw", addr_rw, t.exp_arw);
      for (int i = 0; i < int'(t.n); i++) begin
        if (!t.rw) begin
          if (!t.exp_aack && !t.full) rxq.push_back(d[i]);
          wr_byte(d[i], a);
          chk("data_ack", a, (t.exp_aack || t.full) ? 1 : 0);
        end else begin
          rd_byte(i == int'(t.n) - 1, b);
          chk("rd_data", b, d[i]);
        end
      end
      bus_stop();
      chk("busy_end", busy, 0);
      chk("sda_end", sda_out, 1);
      if (t.addr != 7'h55) chk("sda_never_low", sda_low_cnt, 0);
      full = 1'b0;
      wait_clk(4);
    end
    chk("tx_ready_cnt", tx_ready_cnt, 2);
    chk("txq_drained", txq.size(), 0);

    // Write then repeated START into a read with no tx data available.
    bus_start();
    wr_byte(8'hAA, a);
    chk("sr_w_ack", a, 0);
    rxq.push_back(8'h11);
    wr_byte(8'h11, a);
    chk("sr_data_ack", a, 0);
    bus_start();
    chk("sr_busy_clr", busy, 0);
    wr_byte(8'hAB, a);
    chk("sr_r_ack", a, 0);
    chk("sr_addr_rw", addr_rw, 8'hAB);
    rd_byte(1'b1, b);
    chk("sr_idle_byte", b, 8'hFF);
    bus_stop();
    chk("sr_no_ready", tx_ready_cnt, 2);
    wait_clk(4);

    // STOP after the 4th data bit.
    bus_start();
    wr_byte(8'hAA, a);
    chk("ab_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, a);
    bus_stop();
    chk("ab_busy", busy, 0);
    chk("ab_sda", sda_out, 1);
    wait_clk(4);

    // Disable mid-byte, then bus activity without a START is ignored.
    bus_start();
    wr_byte(8'hAA, a);
    chk("en_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, a);
    en = 1'b0;
    wait_clk(2);
    chk("en_busy", busy, 0);
    chk("en_sda", sda_out, 1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, a);
    bit_xfer(1'b1, a);
    chk("en_off_nack", a, 1);
    en = 1'b1;
    wr_byte(8'h00, a);
    chk("en_nostart_nack", a, 1);
    bus_stop();
    wait_clk(4);
    bus_start();
    wr_byte(8'hAA, a);
    chk("en_fresh_ack", a, 0);
    rxq.push_back(8'h5A);
    wr_byte(8'h5A, a);
    chk("en_fresh_data", a, 0);
    bus_stop();
    wait_clk(4);

    // Asynchronous reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'hAA >> i) & 8'h01) != 0, a);
    wait_clk(Q);
    chk("rs_ack_drive", sda_out, 0);
    chk("rs_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_sda", sda_out, 1);
    chk("rs_busy", busy, 0);
    chk("rs_addr_rw", addr_rw, 0);
    wait_clk(2);
    rst_n = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    wait_clk(8);

    chk("rxq_drained", rxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
